// File: rtl/pep_common_param_pkg.sv
// Shared GRAM parameters and the per-GRAM write-arbiter FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: GRAM_NB (number of GRAM banks), GRAM_ID_W (bank index width),
//           garb_state_e (IDLE / GRANT / GUARD).
package pep_common_param_pkg;

  localparam int GRAM_NB   = 4;
  localparam int GRAM_ID_W = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } garb_state_e;

endpackage

// File: rtl/pep_gram_wr_arb_core.sv
// Single-GRAM write arbiter: round-robin grant, quantum-limited ownership and
// forced guard gap between owners.
// Latency: request sampled in cycle t gives avail_o in cycle t+1.
// Backpressure: a waiting master keeps req_i high; the owner loses the grant
//   after QUANTUM cycles only if another master is waiting.
// Ports: clk, s_rst (sync, active-high), req_i[m] (master m wants this GRAM),
//        avail_o[m] (registered one-hot grant), busy_o (GRANT or GUARD).
module pep_gram_wr_arb_core
  import pep_common_param_pkg::*;
#(
  parameter int MASTER_NB = 3,
  parameter int QUANTUM   = 16,
  parameter int GUARD_CYC = 3
) (
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic [MASTER_NB-1:0] req_i,
  output logic [MASTER_NB-1:0] avail_o,
  output logic                 busy_o
);

  localparam int PTR_W = (MASTER_NB > 1) ? $clog2(MASTER_NB) : 1;
  localparam logic [7:0]       QUANT_C = 8'(QUANTUM);
  localparam logic [3:0]       GUARD_C = 4'(GUARD_CYC);
  localparam logic [PTR_W-1:0] LAST_M  = PTR_W'(MASTER_NB - 1);

  garb_state_e          state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [7:0]           cnt_q;
  logic [3:0]           guard_q;
  logic [MASTER_NB-1:0] avail_q;
  logic                 busy_q;

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [PTR_W-1:0]     owner_nxt;
  logic                 owner_req;
  logic                 others_req;
  logic                 quantum_end;

  // Scan offsets from the far end down so the requester closest to rr_ptr_q
  // is the last one written and therefore wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = MASTER_NB - 1; i >= 0; i--) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % MASTER_NB);
      if (req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign owner_req   = req_i[owner_q];
  // avail_q is the owner's one-hot while in GRANT, so masking with it leaves
  // only the competing requesters.
  assign others_req  = |(req_i & ~avail_q);
  assign quantum_end = (cnt_q == QUANT_C);
  assign owner_nxt   = (owner_q == LAST_M) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      guard_q  <= '0;
      avail_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= GRANT;
            owner_q <= pick_idx;
            avail_q <= MASTER_NB'(1) << pick_idx;
            cnt_q   <= 8'd1;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (!owner_req || (quantum_end && others_req)) begin
            state_q  <= GUARD;
            rr_ptr_q <= owner_nxt;
            avail_q  <= '0;
            cnt_q    <= '0;
            guard_q  <= 4'd1;
          end else if (quantum_end) begin
            // Nobody else waiting: restart the quantum without a gap.
            cnt_q <= 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GUARD: begin
          if (guard_q == GUARD_C) begin
            guard_q <= '0;
            if (pick_vld) begin
              state_q <= GRANT;
              owner_q <= pick_idx;
              avail_q <= MASTER_NB'(1) << pick_idx;
              cnt_q   <= 8'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            guard_q <= guard_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          avail_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avail_o = avail_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/pep_gram_wr_arb.sv
// GRAM write arbiter: one independent round-robin arbiter per GRAM bank.
// Latency: req in cycle t -> avail_1h in cycle t+1; GUARD_CYC idle cycles between owners.
// Backpressure: masters hold req until granted; owners are pre-empted after QUANTUM cycles.
// Ports: clk, s_rst (sync, active-high), req[m][g], avail_1h[m][g] (registered,
//        one-hot per GRAM), gram_busy[g]; stat_wait_cyc[m] only when
//        PEP_GRAM_WR_ARB_STATS_EN is defined (saturating per-master wait counters).
module pep_gram_wr_arb
  import pep_common_param_pkg::*;
#(
  parameter int MASTER_NB = 3,
  parameter int QUANTUM   = 16,
  parameter int GUARD_CYC = 3
) (
  input  logic                              clk,
  input  logic                              s_rst,
  input  logic [MASTER_NB-1:0][GRAM_NB-1:0] req,
  output logic [MASTER_NB-1:0][GRAM_NB-1:0] avail_1h,
  output logic [GRAM_NB-1:0]                gram_busy
`ifdef PEP_GRAM_WR_ARB_STATS_EN
  ,
  output logic [MASTER_NB-1:0][31:0]        stat_wait_cyc
`endif
);

  // Per-GRAM views of the master-major request/grant matrices.
  logic [GRAM_NB-1:0][MASTER_NB-1:0] req_col;
  logic [GRAM_NB-1:0][MASTER_NB-1:0] avail_col;

  for (genvar g = 0; g < GRAM_NB; g++) begin : g_gram
    for (genvar m = 0; m < MASTER_NB; m++) begin : g_master
      assign req_col[g][m]  = req[m][g];
      assign avail_1h[m][g] = avail_col[g][m];
    end

    pep_gram_wr_arb_core #(
      .MASTER_NB (MASTER_NB),
      .QUANTUM   (QUANTUM),
      .GUARD_CYC (GUARD_CYC)
    ) u_core (
      .clk     (clk),
      .s_rst   (s_rst),
      .req_i   (req_col[g]),
      .avail_o (avail_col[g]),
      .busy_o  (gram_busy[g])
    );
  end

`ifdef PEP_GRAM_WR_ARB_STATS_EN
  // A master is waiting when any of its requests is not currently granted.
  logic [MASTER_NB-1:0] wait_vld;

  always_comb begin
    wait_vld = '0;
    for (int m = 0; m < MASTER_NB; m++) begin
      wait_vld[m] = |(req[m] & ~avail_1h[m]);
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      stat_wait_cyc <= '0;
    end else begin
      for (int m = 0; m < MASTER_NB; m++) begin
        if (wait_vld[m] && (stat_wait_cyc[m] != 32'hFFFF_FFFF)) begin
          stat_wait_cyc[m] <= stat_wait_cyc[m] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
